// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use hazards between the ID and EX
// stages, inserts a single bubble per hazard, and flushes the front end for
// FLUSH_CYCLES cycles after a taken branch resolves in EX. Outputs are Mealy
// so a hazard or branch acts in the cycle it is seen.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rn_ID,
  input  logic [4:0]       Rm_ID,
  input  logic             uses_Rn,
  input  logic             uses_Rm,
  input  logic             memRead_EX,
  input  logic [4:0]       targetReg_EX,
  input  logic             branch_taken_EX,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StLuStall = 2'b01,
    StFlush   = 2'b10
  } state_e;

  localparam logic [2:0] FcntReload = 3'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             lu;

  // X31 is the zero register, so a load targeting it never creates a dependency.
  assign lu = memRead_EX && (targetReg_EX != 5'd31) &&
              ((uses_Rn && (Rn_ID == targetReg_EX)) ||
               (uses_Rm && (Rm_ID == targetReg_EX)));

  // Next-state and Mealy outputs; a taken branch takes priority in every state.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (!reset) begin
      if (branch_taken_EX) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        flush_inc    = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = StFlush;
          fcnt_d  = FcntReload;
        end else begin
          state_d = StRun;
        end
      end else begin
        unique case (state_q)
          StRun: begin
            if (lu) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
              stall_inc    = 1'b1;
              state_d      = StLuStall;
            end
          end
          // The stalled consumer re-enters ID here; masking lu keeps it to one bubble.
          StLuStall: state_d = StRun;
          StFlush: begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (fcnt_q <= 3'd1) begin
              state_d = StRun;
              fcnt_d  = 3'd0;
            end else begin
              fcnt_d = fcnt_q - 3'd1;
            end
          end
          default: state_d = StRun;
        endcase
      end
    end
  end

  // State, flush down-counter and saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. The stimulus process drives one vector
// per cycle and queues its hand-computed response; a monitor compares on the
// falling edge. A second instance with CNT_W=4 shares the inputs to check
// counter saturation.
module tb_hazard_ctrl;

  localparam logic [1:0] RUN = 2'b00;
  localparam logic [1:0] LS  = 2'b01;
  localparam logic [1:0] FL  = 2'b10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rn_ID, Rm_ID, targetReg_EX;
  logic       uses_Rn, uses_Rm, memRead_EX, branch_taken_EX;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  state_o;

  logic       s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble;
  logic [3:0] s_stall_cnt, s_flush_cnt;
  logic [1:0] s_state_o;

  typedef struct {
    logic [3:0] en;  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    logic [1:0] st;
    int         sc;
    int         fc;
    int         step;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .uses_Rn(uses_Rn),
    .uses_Rm(uses_Rm), .memRead_EX(memRead_EX), .targetReg_EX(targetReg_EX),
    .branch_taken_EX(branch_taken_EX), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .state_o(state_o)
  );

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .uses_Rn(uses_Rn),
    .uses_Rm(uses_Rm), .memRead_EX(memRead_EX), .targetReg_EX(targetReg_EX),
    .branch_taken_EX(branch_taken_EX), .pc_write(s_pc_write),
    .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
    .state_o(s_state_o)
  );

  task automatic chk(input string name, input int stp, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, stp, act, req);
    end
  endtask

  // One cycle of stimulus plus its expected response (counters as seen this cycle).
  task automatic cyc(input logic r, input logic mr, input logic [4:0] tgt,
                     input logic urn, input logic [4:0] rn, input logic urm,
                     input logic [4:0] rm, input logic br, input logic [3:0] en,
                     input logic [1:0] st, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; memRead_EX = mr; targetReg_EX = tgt; uses_Rn = urn; Rn_ID = rn;
    uses_Rm = urm; Rm_ID = rm; branch_taken_EX = br;
    e.en = en; e.st = st; e.sc = sc; e.fc = fc; e.step = step;
    q.push_back(e);
    step++;
  endtask

  task automatic idle(input logic [3:0] en, input logic [1:0] st, input int sc,
                      input int fc);
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, en, st, sc, fc);
  endtask

  // Monitor: every cycle presents a response, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_write", e.step, int'(pc_write), int'(e.en[3]));
        chk("if_id_write", e.step, int'(if_id_write), int'(e.en[2]));
        chk("if_id_flush", e.step, int'(if_id_flush), int'(e.en[1]));
        chk("id_ex_bubble", e.step, int'(id_ex_bubble), int'(e.en[0]));
        chk("state_o", e.step, int'(state_o), int'(e.st));
        chk("stall_cnt", e.step, int'(stall_cnt), e.sc);
        chk("flush_cnt", e.step, int'(flush_cnt), e.fc);
        chk("sat_stall_cnt", e.step, int'(s_stall_cnt), (e.sc > 15) ? 15 : e.sc);
      end
    end
  end

  initial begin
    reset = 1'b1; memRead_EX = 1'b0; targetReg_EX = '0; uses_Rn = 1'b0; Rn_ID = '0;
    uses_Rm = 1'b0; Rm_ID = '0; branch_taken_EX = 1'b0;
    repeat (2) @(posedge clk);

    // Reset forces enables regardless of hazard and branch inputs.
    cyc(1, 1, 5'd5, 1, 5'd5, 0, 5'd0, 1, 4'b1100, RUN, 0, 0);
    idle(4'b1100, RUN, 0, 0);
    // Load-use on Rn, then a second dependent (Rm) instruction is masked.
    cyc(0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 0, 4'b0001, RUN, 0, 0);
    cyc(0, 1, 5'd5, 1, 5'd5, 1, 5'd5, 0, 4'b1100, LS, 1, 0);
    idle(4'b1100, RUN, 1, 0);
    // X31 never hazards; an unused matching source does not either.
    cyc(0, 1, 5'd31, 0, 5'd0, 1, 5'd31, 0, 4'b1100, RUN, 1, 0);
    cyc(0, 1, 5'd5, 0, 5'd5, 1, 5'd6, 0, 4'b1100, RUN, 1, 0);
    idle(4'b1100, RUN, 1, 0);
    // Single branch: two flush cycles, then RUN.
    cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 4'b1111, RUN, 1, 0);
    idle(4'b1111, FL, 1, 1);
    idle(4'b1100, RUN, 1, 1);
    // Branch together with load-use: branch wins, lu masked during FLUSH.
    cyc(0, 1, 5'd7, 0, 5'd0, 1, 5'd7, 1, 4'b1111, RUN, 1, 1);
    cyc(0, 1, 5'd7, 0, 5'd0, 1, 5'd7, 0, 4'b1111, FL, 1, 2);
    idle(4'b1100, RUN, 1, 2);
    // Branch inside FLUSH reloads the flush window.
    cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 4'b1111, RUN, 1, 2);
    cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 4'b1111, FL, 1, 3);
    idle(4'b1111, FL, 1, 4);
    idle(4'b1100, RUN, 1, 4);
    // Branch during LU_STALL.
    cyc(0, 1, 5'd3, 0, 5'd0, 1, 5'd3, 0, 4'b0001, RUN, 1, 4);
    cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 4'b1111, LS, 2, 4);
    idle(4'b1111, FL, 2, 5);
    idle(4'b1100, RUN, 2, 5);
    // Reset in the second FLUSH cycle.
    cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 4'b1111, RUN, 2, 5);
    cyc(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 4'b1100, FL, 2, 6);
    idle(4'b1100, RUN, 0, 0);
    // Reset during LU_STALL.
    cyc(0, 1, 5'd9, 1, 5'd9, 0, 5'd0, 0, 4'b0001, RUN, 0, 0);
    cyc(1, 1, 5'd9, 1, 5'd9, 0, 5'd0, 0, 4'b1100, LS, 1, 0);
    idle(4'b1100, RUN, 0, 0);
    // 20 load-use events: 16-bit counter reaches 20, 4-bit counter holds at 15.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 5'd2, 1, 5'd2, 0, 5'd0, 0, 4'b0001, RUN, i, 0);
      idle(4'b1100, LS, i + 1, 0);
    end
    idle(4'b1100, RUN, 20, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
